// File: rtl/relogio_pkg.sv
// Shared types and moduli for the BCD clock counters.
package relogio_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        AJUSTE = 1'b1
    } estado_t;

    localparam int MOD_SEG  = 60;
    localparam int MOD_MIN  = 60;
    localparam int MOD_HORA = 24;

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector: one-cycle pulse when the input goes 0 -> 1.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic pulso
);

    logic hist_q, hist_d;

    always_comb begin
        hist_d = entrada;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) hist_q <= 1'b0;
        else        hist_q <= hist_d;
    end

    assign pulso = entrada & ~hist_q;

endmodule

// File: rtl/relogio_cadeia.sv
// Seconds/minutes/hours clock: each stage's wrap pulse is the next stage's tick.
module relogio_cadeia
    import relogio_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       desce,
    input  logic       modo_ajuste,
    input  logic [1:0] sel_ajuste,
    input  logic       btn_mais,
    input  logic       btn_menos,
    output logic [3:0] seg_lsd,
    output logic [2:0] seg_msd,
    output logic [3:0] min_lsd,
    output logic [2:0] min_msd,
    output logic [3:0] hora_lsd,
    output logic [1:0] hora_msd,
    output logic       dia_out,
    output logic       em_ajuste,
    output logic       erro_carga
);

    logic carry_seg, borrow_seg, carry_min, borrow_min, carry_hora, borrow_hora;
    logic aj_seg, aj_min, aj_hora;
    logic erro_seg, erro_min, erro_hora;

    maq_contador_bcd #(.MODULO(MOD_SEG), .MSD_W(3)) u_seg (
        .clock(clock), .reset(reset), .tick(tick_1hz), .desce(desce),
        .modo_ajuste(modo_ajuste && (sel_ajuste == 2'd0)),
        .btn_mais(btn_mais), .btn_menos(btn_menos),
        .carga(1'b0), .carga_lsd(4'd0), .carga_msd(3'd0),
        .bcd_lsd(seg_lsd), .bcd_msd(seg_msd),
        .carry_out(carry_seg), .borrow_out(borrow_seg),
        .erro_carga(erro_seg), .em_ajuste(aj_seg)
    );

    maq_contador_bcd #(.MODULO(MOD_MIN), .MSD_W(3)) u_min (
        .clock(clock), .reset(reset), .tick(carry_seg | borrow_seg), .desce(desce),
        .modo_ajuste(modo_ajuste && (sel_ajuste == 2'd1)),
        .btn_mais(btn_mais), .btn_menos(btn_menos),
        .carga(1'b0), .carga_lsd(4'd0), .carga_msd(3'd0),
        .bcd_lsd(min_lsd), .bcd_msd(min_msd),
        .carry_out(carry_min), .borrow_out(borrow_min),
        .erro_carga(erro_min), .em_ajuste(aj_min)
    );

    maq_contador_bcd #(.MODULO(MOD_HORA), .MSD_W(2)) u_hora (
        .clock(clock), .reset(reset), .tick(carry_min | borrow_min), .desce(desce),
        .modo_ajuste(modo_ajuste && (sel_ajuste == 2'd2)),
        .btn_mais(btn_mais), .btn_menos(btn_menos),
        .carga(1'b0), .carga_lsd(4'd0), .carga_msd(2'd0),
        .bcd_lsd(hora_lsd), .bcd_msd(hora_msd),
        .carry_out(carry_hora), .borrow_out(borrow_hora),
        .erro_carga(erro_hora), .em_ajuste(aj_hora)
    );

    assign dia_out    = carry_hora | borrow_hora;
    assign em_ajuste  = aj_seg | aj_min | aj_hora;
    assign erro_carga = erro_seg | erro_min | erro_hora;

endmodule

// File: rtl/maq_contador_bcd.sv
// Two-digit BCD up/down counter, modulo MODULO, with adjust mode, load and wrap pulses.
module maq_contador_bcd
    import relogio_pkg::*;
#(
    parameter int MODULO            = 60,
    parameter int MSD_W             = 3,
    parameter int GERA_CARRY_AJUSTE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             desce,
    input  logic             modo_ajuste,
    input  logic             btn_mais,
    input  logic             btn_menos,
    input  logic             carga,
    input  logic [3:0]       carga_lsd,
    input  logic [MSD_W-1:0] carga_msd,
    output logic [3:0]       bcd_lsd,
    output logic [MSD_W-1:0] bcd_msd,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             erro_carga,
    output logic             em_ajuste
);

    localparam logic [3:0]       MAX_LSD = 4'((MODULO - 1) % 10);
    localparam logic [MSD_W-1:0] MAX_MSD = MSD_W'((MODULO - 1) / 10);
    localparam logic [MSD_W-1:0] MSD_UM  = MSD_W'(1);

    estado_t          estado_q, estado_d;
    logic [3:0]       lsd_q, lsd_d;
    logic [MSD_W-1:0] msd_q, msd_d;
    logic             em_ajuste_q, em_ajuste_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             erro_q, erro_d;

    logic pulso_mais, pulso_menos;
    logic no_max, no_zero, carga_ok;
    logic sobe, desce_passo, gera_pulso;

    // Detectors run in both states so a button held while entering adjust gives no step.
    detector_borda u_borda_mais (
        .clock   (clock),
        .reset   (reset),
        .entrada (btn_mais),
        .pulso   (pulso_mais)
    );

    detector_borda u_borda_menos (
        .clock   (clock),
        .reset   (reset),
        .entrada (btn_menos),
        .pulso   (pulso_menos)
    );

    always_comb begin
        no_max   = (lsd_q == MAX_LSD) && (msd_q == MAX_MSD);
        no_zero  = (lsd_q == 4'd0) && (msd_q == '0);
        carga_ok = (carga_lsd <= 4'd9) &&
                   ((32'(carga_msd) * 32'd10 + 32'(carga_lsd)) < 32'(MODULO));

        sobe        = 1'b0;
        desce_passo = 1'b0;
        gera_pulso  = 1'b1;
        if (estado_q == AJUSTE) begin
            sobe        = pulso_mais & ~pulso_menos;
            desce_passo = pulso_menos & ~pulso_mais;
            gera_pulso  = (GERA_CARRY_AJUSTE != 0);
        end else begin
            sobe        = tick & ~desce;
            desce_passo = tick & desce;
        end

        lsd_d    = lsd_q;
        msd_d    = msd_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        erro_d   = 1'b0;

        // Full-value wrap is tested before the digit rules so MODULO-1 never rolls to MODULO.
        if (carga) begin
            if (carga_ok) begin
                lsd_d = carga_lsd;
                msd_d = carga_msd;
            end else begin
                erro_d = 1'b1;
            end
        end else if (sobe) begin
            if (no_max) begin
                lsd_d   = 4'd0;
                msd_d   = '0;
                carry_d = gera_pulso;
            end else if (lsd_q == 4'd9) begin
                lsd_d = 4'd0;
                msd_d = msd_q + MSD_UM;
            end else begin
                lsd_d = lsd_q + 4'd1;
            end
        end else if (desce_passo) begin
            if (no_zero) begin
                lsd_d    = MAX_LSD;
                msd_d    = MAX_MSD;
                borrow_d = gera_pulso;
            end else if (lsd_q == 4'd0) begin
                lsd_d = 4'd9;
                msd_d = msd_q - MSD_UM;
            end else begin
                lsd_d = lsd_q - 4'd1;
            end
        end

        estado_d = estado_q;
        case (estado_q)
            NORMAL:  if (modo_ajuste)  estado_d = AJUSTE;
            AJUSTE:  if (!modo_ajuste) estado_d = NORMAL;
            default: estado_d = NORMAL;
        endcase
        em_ajuste_d = (estado_d == AJUSTE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= NORMAL;
            lsd_q       <= 4'd0;
            msd_q       <= '0;
            em_ajuste_q <= 1'b0;
            carry_q     <= 1'b0;
            borrow_q    <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            lsd_q       <= lsd_d;
            msd_q       <= msd_d;
            em_ajuste_q <= em_ajuste_d;
            carry_q     <= carry_d;
            borrow_q    <= borrow_d;
            erro_q      <= erro_d;
        end
    end

    assign bcd_lsd    = lsd_q;
    assign bcd_msd    = msd_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign erro_carga = erro_q;
    assign em_ajuste  = em_ajuste_q;

endmodule

// File: doc/maq_contador_bcd.md
MAQ_CONTADOR_BCD -- requirements
Module: maq_contador_bcd

Interface
REQ-001 Parameter MODULO, default 60, count range 0..MODULO-1; legal 2..100.
REQ-002 Parameter MSD_W, default 3, width of tens digit; SHALL hold (MODULO-1)/10.
REQ-003 Parameter GERA_CARRY_AJUSTE, default 0, 1 = carry/borrow also pulse during adjust mode.
REQ-004 clock  in  1  system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 tick  in  1  one-cycle count-enable pulse (1 Hz enable or upstream carry).
REQ-007 desce  in  1  0 = count up, 1 = count down; sampled with tick.
REQ-008 modo_ajuste  in  1  level, 1 = adjust mode.
REQ-009 btn_mais / btn_menos  in  1 each  raw synchronous adjust buttons (level).
REQ-010 carga  in  1  one-cycle load strobe.
REQ-011 carga_lsd  in  4, carga_msd  in  MSD_W  BCD load value.
REQ-012 bcd_lsd  out  4, bcd_msd  out  MSD_W  current value, BCD.
REQ-013 carry_out  out  1  one-cycle pulse on up-wrap MODULO-1 -> 0.
REQ-014 borrow_out  out  1  one-cycle pulse on down-wrap 0 -> MODULO-1.
REQ-015 erro_carga  out  1  one-cycle pulse on rejected load.
REQ-016 em_ajuste  out  1  registered copy of current state == AJUSTE.

Function
REQ-017 FSM states NORMAL, AJUSTE; NORMAL->AJUSTE when modo_ajuste=1, AJUSTE->NORMAL when modo_ajuste=0; transition takes effect at next clock edge.
REQ-018 NORMAL: tick=1 -> value +1 (desce=0) or -1 (desce=1) at that edge; tick=0 -> hold.
REQ-019 Increment: lsd 9 -> 0 with msd+1; value MODULO-1 -> 00 and carry_out=1 in following cycle.
REQ-020 Decrement: lsd 0 -> 9 with msd-1; value 00 -> MODULO-1 (both digits) and borrow_out=1 in following cycle.
REQ-021 Wrap SHALL check full value MODULO-1 before lsd==9 rule (e.g. MODULO=24: 23 -> 00, never 24; MODULO=60: 59 -> 00, never 60).
REQ-022 carry_out/borrow_out registered, high exactly one cycle, 0 otherwise; consecutive ticks on wrap each produce their own pulse.
REQ-023 AJUSTE: tick ignored; rising edge of btn_mais -> +1, of btn_menos -> -1, same wrap rules; held buttons give one step only.
REQ-024 AJUSTE wraps pulse carry_out/borrow_out only if GERA_CARRY_AJUSTE=1.
REQ-025 Both button edges in same cycle -> no change.
REQ-026 Button edge detector SHALL track buttons in both states; button held when entering AJUSTE gives no step.
REQ-027 carga=1 with value < MODULO and both digits valid BCD -> load at that edge, no carry/borrow.
REQ-028 carga=1 with invalid value (lsd>9 or value>=MODULO) -> value unchanged, erro_carga=1 next cycle.
REQ-029 Priority per edge: carga > adjust step > tick; lower-priority event that cycle is dropped.
REQ-030 Value SHALL never leave 0..MODULO-1 in any state.

Reset
REQ-031 reset=0 asynchronously forces: value 00, state NORMAL, em_ajuste=0, carry_out=0, borrow_out=0, erro_carga=0, edge-detector history 0.
REQ-032 Reset asserted mid-adjust or mid-pulse aborts it; no pulse after release.
REQ-033 First edge after reset release acts normally (tick on that edge counts).

Structure
REQ-034 Package relogio_pkg SHALL hold state enum (NORMAL, AJUSTE) and constants MOD_SEG=60, MOD_MIN=60, MOD_HORA=24.
REQ-035 Sub-module detector_borda (rising-edge pulse, async active-low reset) SHALL be instantiated once per button.
REQ-036 Seconds/minutes/hours chain SHALL be built by cascading carry_out into next stage tick.

Verification
REQ-037 MODULO=60, value 58, two ticks -> 59 then 00, carry_out=1 one cycle after second tick.
REQ-038 MODULO=24, desce=1, value 00, one tick -> 23, borrow_out pulse one cycle.
REQ-039 MODULO=60, carga 7/5 (75) -> value unchanged, erro_carga pulse; carga 5/9 -> 59 loaded.
REQ-040 AJUSTE at 59, btn_mais held 10 cycles, ticks every cycle -> single step to 00, no carry_out (GERA_CARRY_AJUSTE=0).
REQ-041 carga and tick same edge, load 3/0 -> value 30, tick dropped.
REQ-042 reset=0 between clock edges during adjust at value 42 -> outputs 00/NORMAL immediately, before next edge.
